alt_vipitc130_common_sc_fifo: RTL

Single-clock, parametrised FIFO for the VIP clocked-video datapath; the successor to the common vendor-FIFO wrapper for the same-clock case. It infers its own RAM instead of instantiating a vendor macro, and adds:
- arbitrary (non-power-of-2) depth;
- selectable normal/show-ahead read mode;
- almost-full/almost-empty thresholds;
- sticky overflow/underflow detection with protection;
- a synchronous flush.

It sits between the line-buffer writer and the ITC output sequencer.

---
 rtl/alt_vipitc130_common_sc_fifo.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alt_vipitc130_common_sc_fifo.sv
// Single-clock FIFO with arbitrary depth, normal or show-ahead read, threshold flags,
// sticky overflow/underflow and a synchronous flush. Storage is an inferred RAM.
module alt_vipitc130_common_sc_fifo #(
    parameter int DATA_WIDTH         = 20,
    parameter int FIFO_DEPTH         = 1920,
    parameter int SHOWAHEAD          = 0,
    parameter int ALMOST_FULL_LEVEL  = FIFO_DEPTH - 4,
    parameter int ALMOST_EMPTY_LEVEL = 4,
    parameter int USEDW_WIDTH        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   aclr_n,
    input  logic                   sclr,
    input  logic                   wrreq,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic                   rdreq,
    output logic [DATA_WIDTH-1:0]  q,
    output logic [USEDW_WIDTH-1:0] usedw,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [USEDW_WIDTH-1:0] DEPTH_W  = USEDW_WIDTH'(FIFO_DEPTH);
    localparam logic [USEDW_WIDTH-1:0] AF_W     = USEDW_WIDTH'(ALMOST_FULL_LEVEL);
    localparam logic [USEDW_WIDTH-1:0] AE_W     = USEDW_WIDTH'(ALMOST_EMPTY_LEVEL);
    localparam logic [USEDW_WIDTH-1:0] ONE_W    = USEDW_WIDTH'(1);

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_inc;
    logic [USEDW_WIDTH-1:0] usedw_q, usedw_d;
    logic                   empty_q, empty_d;
    logic                   full_q, full_d;
    logic                   almost_empty_q, almost_empty_d;
    logic                   almost_full_q, almost_full_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0]  q_q, q_d;
    logic                   wr_acc, rd_acc;

    always_comb begin
        wr_acc     = !sclr && wrreq && (!full_q || rdreq);
        rd_acc     = !sclr && rdreq && !empty_q;
        rd_ptr_inc = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usedw_d  = usedw_q;
        if (sclr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usedw_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_inc;
            end
            case ({wr_acc, rd_acc})
                2'b10:   usedw_d = usedw_q + ONE_W;
                2'b01:   usedw_d = usedw_q - ONE_W;
                default: usedw_d = usedw_q;
            endcase
        end

        // Flags come from the next count so they never lag usedw.
        empty_d        = (usedw_d == '0);
        full_d         = (usedw_d == DEPTH_W);
        almost_empty_d = (usedw_d < AE_W);
        almost_full_d  = (usedw_d >= AF_W);

        overflow_d  = !sclr && (overflow_q || (wrreq && full_q && !rdreq));
        underflow_d = !sclr && (underflow_q || (rdreq && empty_q));

        q_d = q_q;
        if (SHOWAHEAD != 0) begin
            // The head word bypasses the RAM when the FIFO is, or is about to become, empty.
            if (wr_acc && (empty_q || (rd_acc && usedw_q == ONE_W))) begin
                q_d = data;
            end else if (rd_acc && usedw_q != ONE_W) begin
                q_d = mem[rd_ptr_inc];
            end
        end else begin
            if (rd_acc) begin
                q_d = mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            usedw_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            q_q            <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            usedw_q        <= usedw_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_empty_q <= almost_empty_d;
            almost_full_q  <= almost_full_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            q_q            <= q_d;
        end
    end

    assign q            = q_q;
    assign usedw        = usedw_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = almost_empty_q;
    assign almost_full  = almost_full_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
